reg_unit_arbiter: RTL
=====================

Name: reg_unit_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port register file (CLK/RST, WrEn, RdEn, Address, WrData, RdData).
- Serialises requests from masters M0 and M1 into single-cycle register-file accesses.
- Returns read data to the owning master with a valid pulse.
- Sits between the register file and its two clients, e.g. the CPU-side config port and the DMA/test port.

Parameters:
- REG_WIDTH, 16, data width of register file and master data ports
- ADDR_WIDTH, 3, register address width (depth = 2**ADDR_WIDTH)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- M0_Req  input  1  M0 access request; held high with command stable until M0_Gnt
- M0_WrEn  input  1  M0 command: 1 = write, 0 = read
- M0_Addr  input  ADDR_WIDTH  M0 register address
- M0_WrData  input  REG_WIDTH  M0 write data
- M0_Gnt  output  1  one-cycle pulse: M0 command issued this cycle
- M0_RdData  output  REG_WIDTH  M0 read result, held until next M0 read completes
- M0_RdValid  output  1  one-cycle pulse: M0_RdData updated
- M1_Req, M1_WrEn, M1_Addr, M1_WrData, M1_Gnt, M1_RdData, M1_RdValid  same as M0 for M1
- WrEn  output  1  register-file write enable
- RdEn  output  1  register-file read enable
- Address  output  ADDR_WIDTH  register-file address
- WrData  output  REG_WIDTH  register-file write data
- RdData  input  REG_WIDTH  register-file read data, valid the cycle after RdEn is sampled

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; round-robin pointer = M0.
- FSM states: IDLE, ACCESS, RDRESP.
- IDLE:
  - No Req: stay in IDLE.
  - Any Req: pick the winner, latch its WrEn/Addr/WrData and owner ID, go to ACCESS.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the pointer master wins.
  - Pointer moves to the non-winner after each grant.
- ACCESS (exactly 1 cycle):
  - Drive Address/WrData from the latched command.
  - Assert WrEn (write) or RdEn (read); never both.
  - Assert owner Gnt.
  - Write: go to IDLE. Read: go to RDRESP.
- RDRESP (1 cycle):
  - Register file drives RdData.
  - At the end of this cycle, RdData is captured into owner Mx_RdData and Mx_RdValid is set.
  - Mx_RdValid is visible during the following cycle (IDLE); go to IDLE.
- Outside ACCESS: WrEn = RdEn = 0; Address/WrData hold their last values.
- Latency, counted from Req first sampled high in IDLE (cycle 0):
  - Gnt and register-file strobe in cycle 1.
  - Write complete at end of cycle 1.
  - RdValid in cycle 3.
- Throughput: write 2 cycles/access, read 3 cycles/access.
- Requester rule: deassert Req (or present the next command) in the cycle after Gnt. A Req still high in IDLE is treated as a new request.
- Requests arriving while the FSM is in ACCESS or RDRESP wait; they are not dropped.
- Command inputs are sampled only in IDLE. Changes after sampling do not affect the issued access.
- Gnt and RdValid go only to the owning master. The other master's outputs are unchanged.
- Back-to-back: both masters holding Req continuously alternate grants M0, M1, M0, ...
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0.
  - Any in-flight access is abandoned: no Gnt or RdValid is issued for it.
  - Pointer returns to M0.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'b00, ACCESS = 2'b01, RDRESP = 2'b10), owner ID constants (OWN_M0 = 1'b0, OWN_M1 = 1'b1).
- One natural sub-module: rr_arbiter_2, combinational grant selection from {M1_Req, M0_Req} and the pointer, plus the pointer register.
- FSM, command latch and response routing stay in the top module.

Test Plan:
- Reset: hold RST = 1 for 2 cycles with both Req high -> all outputs 0, no Gnt; release -> M0 granted first.
- M0 write Addr = 3'b101, WrData = 16'h0007 -> M0_Gnt, WrEn = 1, Address = 5, WrData = 7 in cycle 1; M1 outputs stay 0.
- M1 read Addr = 3'b101 after that write, arbiter connected to the register file -> M1_RdValid in cycle 3 with M1_RdData = 16'h0007; M0_RdValid stays 0.
- M0 and M1 request simultaneously and hold continuously: M0 write Addr = 7, data 16'h000F; M1 read Addr = 7 -> grant order M0, M1, M0, M1; M1 reads 16'h000F.
- M1 issues a new request while M0's read is in RDRESP -> M1 not granted before the next IDLE; request not lost; M0_RdValid single pulse.
- Assert RST during ACCESS of an M1 read -> no M1_Gnt/M1_RdValid afterwards, RdEn drops immediately, next arbitration starts at M0.

Source files
------------

// File: rtl/reg_unit_arbiter_pkg.sv
// Shared encodings for the register-file arbiter: FSM states and owner IDs.
package reg_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StRdResp = 2'b10
  } state_e;

  localparam logic OwnM0 = 1'b0;
  localparam logic OwnM1 = 1'b1;

endpackage

// File: rtl/reg_unit_arbiter_rr.sv
// Two-way round-robin grant selection with its pointer register.
module rr_arbiter_2
  import reg_unit_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       valid_o,
  output logic       owner_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      owner_o = ptr_q;
    end else begin
      owner_o = req_i[1] ? OwnM1 : OwnM0;
    end
    ptr_d = ptr_q;
    // Pointer always moves to the master that lost (or did not ask).
    if (advance_i && valid_o) begin
      ptr_d = ~owner_o;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= OwnM0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_unit_arbiter.sv
// Serialises two masters onto a single-port register file; read data is routed
// back to the owning master with a one-cycle valid pulse.
module reg_unit_arbiter
  import reg_unit_arbiter_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  M0_Req,
  input  logic                  M0_WrEn,
  input  logic [ADDR_WIDTH-1:0] M0_Addr,
  input  logic [REG_WIDTH-1:0]  M0_WrData,
  output logic                  M0_Gnt,
  output logic [REG_WIDTH-1:0]  M0_RdData,
  output logic                  M0_RdValid,
  input  logic                  M1_Req,
  input  logic                  M1_WrEn,
  input  logic [ADDR_WIDTH-1:0] M1_Addr,
  input  logic [REG_WIDTH-1:0]  M1_WrData,
  output logic                  M1_Gnt,
  output logic [REG_WIDTH-1:0]  M1_RdData,
  output logic                  M1_RdValid,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [REG_WIDTH-1:0]  WrData,
  input  logic [REG_WIDTH-1:0]  RdData
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rdv0_q, rdv0_d, rdv1_q, rdv1_d;
  logic [REG_WIDTH-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;

  logic arb_valid, arb_owner, arb_advance, sel_we;

  rr_arbiter_2 u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req_i     ({M1_Req, M0_Req}),
    .advance_i (arb_advance),
    .valid_o   (arb_valid),
    .owner_o   (arb_owner)
  );

  assign sel_we = (arb_owner == OwnM1) ? M1_WrEn : M0_WrEn;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rdv0_d      = 1'b0;
    rdv1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    arb_advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Command is latched straight into the output registers so the
        // strobe, address and grant all appear together in ACCESS.
        if (arb_valid) begin
          arb_advance = 1'b1;
          owner_d     = arb_owner;
          we_d        = sel_we;
          addr_d      = (arb_owner == OwnM1) ? M1_Addr : M0_Addr;
          wdata_d     = (arb_owner == OwnM1) ? M1_WrData : M0_WrData;
          wr_en_d     = sel_we;
          rd_en_d     = ~sel_we;
          gnt0_d      = (arb_owner == OwnM0);
          gnt1_d      = (arb_owner == OwnM1);
          state_d     = StAccess;
        end
      end
      StAccess: begin
        state_d = we_q ? StIdle : StRdResp;
      end
      StRdResp: begin
        if (owner_q == OwnM1) begin
          rdata1_d = RdData;
          rdv1_d   = 1'b1;
        end else begin
          rdata0_d = RdData;
          rdv0_d   = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      owner_q  <= OwnM0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rdv0_q   <= 1'b0;
      rdv1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rdv0_q   <= rdv0_d;
      rdv1_q   <= rdv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign M0_Gnt     = gnt0_q;
  assign M1_Gnt     = gnt1_q;
  assign M0_RdValid = rdv0_q;
  assign M1_RdValid = rdv1_q;
  assign M0_RdData  = rdata0_q;
  assign M1_RdData  = rdata1_q;
  assign WrEn       = wr_en_q;
  assign RdEn       = rd_en_q;
  assign Address    = addr_q;
  assign WrData     = wdata_q;

endmodule
